// File: rtl/scarv_cop_cprs_wb.sv
// Coprocessor register-file writeback stage: accepts one narrow or wide result
// and writes it into the CPR file as one or two 32-bit word writes.
module scarv_cop_cprs_wb (
  input  logic        g_clk,
  input  logic        g_resetn,
  output logic        g_clk_req,
  input  logic        cprs_init,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [3:0]  wb_addr,
  input  logic        wb_wide,
  input  logic [3:0]  wb_wen,
  input  logic [63:0] wb_data,
  output logic [3:0]  crd_wen,
  output logic [3:0]  crd_addr,
  output logic [31:0] crd_wdata,
  output logic [15:0] wb_pending
);

  localparam int unsigned AW   = 4;
  localparam int unsigned BW   = 4;
  localparam int unsigned WW   = 32;
  localparam int unsigned DW   = 2 * WW;
  localparam int unsigned NREG = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            wide_q, wide_d;
  logic [BW-1:0]   wen_q, wen_d;
  logic [DW-1:0]   data_q, data_d;
  logic [AW-1:0]   addr_hi;
  logic            xfer;

  assign addr_hi = addr_q + AW'(1);

  // Busy only while the low word of a wide pair is being written.
  assign wb_ready  = !cprs_init && !((state_q == WR_LO) && wide_q);
  assign xfer      = wb_valid && wb_ready;
  assign g_clk_req = wb_valid || (state_q != IDLE);

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wide_q  <= 1'b0;
      wen_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wide_q  <= wide_d;
      wen_q   <= wen_d;
      data_q  <= data_d;
    end
  end

  // Next state, holding-register capture and register-file write port.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wide_d     = wide_q;
    wen_d      = wen_q;
    data_d     = data_q;
    crd_wen    = '0;
    crd_addr   = '0;
    crd_wdata  = '0;
    wb_pending = '0;

    if (xfer) begin
      addr_d = wb_addr;
      wide_d = wb_wide;
      wen_d  = wb_wen;
      data_d = wb_data;
    end

    case (state_q)
      IDLE: begin
        state_d = xfer ? WR_LO : IDLE;
      end
      WR_LO: begin
        crd_addr   = addr_q;
        crd_wdata  = data_q[WW-1:0];
        crd_wen    = wide_q ? BW'(4'hF) : wen_q;
        wb_pending = (NREG'(1) << addr_q) | (wide_q ? (NREG'(1) << addr_hi) : NREG'(0));
        if (wide_q) state_d = WR_HI;
        else        state_d = xfer ? WR_LO : IDLE;
      end
      WR_HI: begin
        crd_addr   = addr_hi;
        crd_wdata  = data_q[DW-1:WW];
        crd_wen    = BW'(4'hF);
        wb_pending = NREG'(1) << addr_hi;
        state_d    = xfer ? WR_LO : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Flush: suppress this cycle's write and drop whatever is held.
    if (cprs_init) begin
      crd_wen = '0;
      state_d = IDLE;
    end
  end

endmodule

// File: tb/tb_scarv_cop_cprs_wb.sv
// Scoreboard bench for scarv_cop_cprs_wb: the driver queues the word writes each
// accepted result must produce; a negedge monitor checks every cycle against them.
module tb_scarv_cop_cprs_wb;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        g_clk_req;
  logic        cprs_init;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_addr;
  logic        wb_wide;
  logic [3:0]  wb_wen;
  logic [63:0] wb_data;
  logic [3:0]  crd_wen;
  logic [3:0]  crd_addr;
  logic [31:0] crd_wdata;
  logic [15:0] wb_pending;

  typedef struct packed {
    logic [3:0]  addr;
    logic [3:0]  wen;
    logic [31:0] data;
    logic [15:0] pend;
    logic        rdy;
  } wr_t;

  wr_t exp_q[$];
  int  cmp_cnt = 0;
  int  err_cnt = 0;

  scarv_cop_cprs_wb dut (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
    .g_clk_req  (g_clk_req),
    .cprs_init  (cprs_init),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_addr    (wb_addr),
    .wb_wide    (wb_wide),
    .wb_wen     (wb_wen),
    .wb_data    (wb_data),
    .crd_wen    (crd_wen),
    .crd_addr   (crd_addr),
    .crd_wdata  (crd_wdata),
    .wb_pending (wb_pending)
  );

  always #5 g_clk = ~g_clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    cmp_cnt++;
    if (act !== expv) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [15:0] bit_of(input int r);
    logic [15:0] v;
    v = '0;
    v[r % 16] = 1'b1;
    return v;
  endfunction

  // Reference: a result turns into one (narrow) or two (wide) word writes.
  task automatic push_result(input logic [3:0] a, input logic w, input logic [3:0] wen,
                             input logic [63:0] d);
    wr_t e;
    int  lo, hi;
    lo = int'(a);
    hi = (lo + 1) % 16;
    if (w) begin
      e = '{addr: 4'(lo), wen: 4'hF, data: d[31:0], pend: bit_of(lo) | bit_of(hi), rdy: 1'b0};
      exp_q.push_back(e);
      e = '{addr: 4'(hi), wen: 4'hF, data: d[63:32], pend: bit_of(hi), rdy: 1'b1};
      exp_q.push_back(e);
    end else begin
      e = '{addr: 4'(lo), wen: wen, data: d[31:0], pend: bit_of(lo), rdy: 1'b1};
      exp_q.push_back(e);
    end
  endtask

  // One stimulus cycle; the result is queued if the next edge will accept it.
  task automatic cyc(input logic v, input logic [3:0] a, input logic w, input logic [3:0] wen,
                     input logic [63:0] d, input logic ini);
    @(posedge g_clk); #1;
    wb_valid  = v;
    wb_addr   = a;
    wb_wide   = w;
    wb_wen    = wen;
    wb_data   = d;
    cprs_init = ini;
    @(negedge g_clk); #1;
    if (v && !ini && wb_ready) push_result(a, w, wen, d);
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 4'($urandom), 1'b0, 4'($urandom), {$urandom, $urandom}, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rst_wen"},     64'(crd_wen), 64'h0);
    chk({tag, "_rst_addr"},    64'(crd_addr), 64'h0);
    chk({tag, "_rst_wdata"},   64'(crd_wdata), 64'h0);
    chk({tag, "_rst_pending"}, 64'(wb_pending), 64'h0);
    chk({tag, "_rst_ready"},   64'(wb_ready), 64'h1);
    chk({tag, "_rst_clkreq"},  64'(g_clk_req), 64'(wb_valid));
  endtask

  // Async reset between edges, after the monitor has sampled the current cycle.
  task automatic mid_cycle_reset(input string tag);
    @(posedge g_clk); #1;
    wb_valid = 1'b0;
    @(negedge g_clk); #2;
    g_resetn = 1'b0;
    #1;
    check_reset_outputs(tag);
    exp_q.delete();
    @(posedge g_clk); #1;
    g_resetn = 1'b1;
  endtask

  // Monitor: every cycle either shows the next queued write or is idle.
  always @(negedge g_clk) begin
    wr_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("wr_wen",     64'(crd_wen), cprs_init ? 64'h0 : 64'(e.wen));
      chk("wr_addr",    64'(crd_addr), 64'(e.addr));
      chk("wr_wdata",   64'(crd_wdata), 64'(e.data));
      chk("wr_pending", 64'(wb_pending), 64'(e.pend));
      chk("wr_ready",   64'(wb_ready), cprs_init ? 64'h0 : 64'(e.rdy));
      chk("wr_clkreq",  64'(g_clk_req), 64'h1);
    end else begin
      chk("idle_wen",     64'(crd_wen), 64'h0);
      chk("idle_addr",    64'(crd_addr), 64'h0);
      chk("idle_wdata",   64'(crd_wdata), 64'h0);
      chk("idle_pending", 64'(wb_pending), 64'h0);
      chk("idle_ready",   64'(wb_ready), cprs_init ? 64'h0 : 64'h1);
      chk("idle_clkreq",  64'(g_clk_req), 64'(wb_valid));
    end
    if (cprs_init) exp_q.delete();
  end

  initial begin
    g_resetn  = 1'b0;
    cprs_init = 1'b0;
    wb_valid  = 1'b0;
    wb_addr   = '0;
    wb_wide   = 1'b0;
    wb_wen    = '0;
    wb_data   = '0;
    #2;
    check_reset_outputs("por");
    wb_valid = 1'b1;
    #1;
    check_reset_outputs("por_v");
    wb_valid = 1'b0;
    repeat (2) @(posedge g_clk);
    #1;
    g_resetn = 1'b1;

    // Narrow write, partial byte enables.
    cyc(1'b1, 4'd3, 1'b0, 4'b0101, 64'h0123_4567_AABB_CCDD, 1'b0);
    idle_cyc();
    idle_cyc();

    // Wide write wrapping from CPR 15 to CPR 0.
    cyc(1'b1, 4'd15, 1'b1, 4'b0000, 64'h1111_2222_3333_4444, 1'b0);
    idle_cyc();
    idle_cyc();
    idle_cyc();

    // Streaming narrow writes, then a narrow write with no byte enables.
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 4'(i), 1'b0, 4'(4'h1 << i), {$urandom, $urandom}, 1'b0);
    cyc(1'b1, 4'd9, 1'b0, 4'b0000, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
    idle_cyc();
    idle_cyc();

    // Flush while the low word of a wide pair is being written.
    cyc(1'b1, 4'd5, 1'b1, 4'b0000, 64'h5555_6666_7777_8888, 1'b0);
    cyc(1'b1, 4'd6, 1'b0, 4'hF, 64'h0, 1'b1);
    idle_cyc();
    idle_cyc();

    // Async reset during the high-word write, then during the low-word write.
    cyc(1'b1, 4'd7, 1'b1, 4'b0000, 64'h9999_AAAA_BBBB_CCCC, 1'b0);
    idle_cyc();
    mid_cycle_reset("rst_hi");
    idle_cyc();
    cyc(1'b1, 4'd12, 1'b1, 4'b0000, 64'hFEDC_BA98_7654_3210, 1'b0);
    mid_cycle_reset("rst_lo");
    idle_cyc();
    idle_cyc();

    // Random traffic with occasional flushes.
    for (int n = 0; n < 400; n++) begin
      cyc(1'($urandom_range(0, 99) < 65), 4'($urandom), 1'($urandom_range(0, 99) < 40),
          4'($urandom), {$urandom, $urandom}, 1'($urandom_range(0, 99) < 5));
    end
    repeat (4) idle_cyc();
    chk("drain", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
